// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory arbiter:
// FSM state encoding and default geometry.
package mem_arb_pkg;

  localparam int ADDR_W_DEF      = 8;
  localparam int MAX_D_BURST_DEF = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GNT_I = 3'd1,
    GNT_D = 3'd2,
    RSP_I = 3'd3,
    RSP_D = 3'd4
  } arb_state_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts data grants won while fetch waits;
// saturates at MAX and flags when fetch must win.
module arb_starve_ctr #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign at_max_o = (cnt_q == W'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_max_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Fetch/data arbiter in front of one single-port,
// variable-latency unified memory.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int MAX_D_BURST = MAX_D_BURST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [WIDTH-1:0]  if_addr,
  output logic [WIDTH-1:0]  if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [WIDTH-1:0]  d_addr,
  input  logic [WIDTH-1:0]  d_wdata,
  output logic [WIDTH-1:0]  d_rdata,
  output logic              d_ready,
  output logic              stall_if,
  output logic              stall_d,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_ack
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [WIDTH-1:0]  if_rdata_q, if_rdata_d;
  logic [WIDTH-1:0]  d_rdata_q, d_rdata_d;
  logic              grant_i, grant_d;
  logic              at_max;

  // Byte-offset and high address bits never reach the memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[WIDTH-1:ADDR_W+2],
                              if_addr[1:0],
                              d_addr[WIDTH-1:ADDR_W+2],
                              d_addr[1:0]};

  arb_starve_ctr #(
    .MAX (MAX_D_BURST)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc_i    (grant_d & if_req),
    .clr_i    (grant_i | (grant_d & ~if_req)),
    .at_max_o (at_max)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (d_req && (!if_req || !at_max)) begin
          grant_d = 1'b1;
          state_d = GNT_D;
          addr_d  = d_addr[ADDR_W+1:2];
          we_d    = d_we;
          wdata_d = d_wdata;
        end else if (if_req) begin
          grant_i = 1'b1;
          state_d = GNT_I;
          addr_d  = if_addr[ADDR_W+1:2];
          we_d    = 1'b0;
          wdata_d = '0;
        end
      end
      GNT_I: begin
        if (mem_ack) begin
          if_rdata_d = mem_rdata;
          state_d    = RSP_I;
        end
      end
      GNT_D: begin
        if (mem_ack) begin
          if (!we_q) begin
            d_rdata_d = mem_rdata;
          end
          state_d = RSP_D;
        end
      end
      RSP_I, RSP_D: state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign mem_en    = (state_q == GNT_I) || (state_q == GNT_D);
  assign mem_we    = we_q & mem_en;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_ready  = (state_q == RSP_I);
  assign d_ready   = (state_q == RSP_D);
  assign stall_if  = if_req & ~if_ready;
  assign stall_d   = d_req & ~d_ready;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios then
// random traffic against a transaction-level memory model.
module tb_unified_mem_arbiter;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        stall_if, stall_d;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(
    .WIDTH       (32),
    .ADDR_W      (8),
    .MAX_D_BURST (MAXB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .stall_if  (stall_if),
    .stall_d   (stall_d),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference: 0 = free, 1 = access on the bus, 2 = completing
  logic [31:0] mem [256];
  int          ms = 0;
  bit          t_kind;
  logic [7:0]  t_addr;
  bit          t_we;
  logic [31:0] t_wd;
  logic [31:0] exp_ird = '0;
  logic [31:0] exp_drd = '0;
  int          streak = 0;
  int          wait_n = 0;
  int          fix_wait = -1;
  bit          spur = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    bit rst_was;
    bit rdy_i, rdy_d;
    @(negedge clk);
    rst_was = rst;
    if (rst_was) begin
      ms = 0;
      exp_ird = '0;
      exp_drd = '0;
      streak = 0;
    end else begin
      case (ms)
        0: begin
          if (if_req || d_req) begin
            if (d_req && (!if_req || streak < MAXB)) begin
              t_kind = 1'b1;
              streak = if_req ? streak + 1 : 0;
              t_addr = d_addr[9:2];
              t_we = d_we;
              t_wd = d_wdata;
            end else begin
              t_kind = 1'b0;
              streak = 0;
              t_addr = if_addr[9:2];
              t_we = 1'b0;
              t_wd = '0;
            end
            ms = 1;
            wait_n = (fix_wait >= 0) ? fix_wait
                                     : int'($urandom_range(0, 3));
          end
        end
        1: begin
          if (mem_ack) begin
            if (t_we) mem[t_addr] = t_wd;
            else if (t_kind) exp_drd = mem[t_addr];
            else exp_ird = mem[t_addr];
            ms = 2;
          end
        end
        default: ms = 0;
      endcase
    end
    rdy_i = (ms == 2) && !t_kind;
    rdy_d = (ms == 2) && t_kind;
    chk("mem_en", mem_en, ms == 1);
    if (ms == 1) begin
      chk("mem_addr", mem_addr, t_addr);
      chk("mem_we", mem_we, t_we);
      if (t_we) chk("mem_wdata", mem_wdata, t_wd);
    end
    if (rst_was) begin
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_we", mem_we, 0);
    end
    chk("if_ready", if_ready, rdy_i);
    chk("d_ready", d_ready, rdy_d);
    chk("if_rdata", if_rdata, exp_ird);
    chk("d_rdata", d_rdata, exp_drd);
    chk("stall_if", stall_if, if_req & ~rdy_i);
    chk("stall_d", stall_d, d_req & ~rdy_d);
    mem_ack = 1'b0;
    mem_rdata = $urandom;
    if (ms == 1) begin
      if (wait_n == 0) begin
        mem_ack = 1'b1;
        if (!t_we) mem_rdata = mem[t_addr];
      end else begin
        wait_n--;
      end
    end else if (spur && $urandom_range(0, 3) == 0) begin
      mem_ack = 1'b1;
    end
  endtask

  initial begin
    int en_cnt, nd, first;
    bit got_i, got_d, done;

    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Lone fetch, ack in the first grant cycle
    mem[4] = 32'h2008_0005;
    fix_wait = 0;
    if_req = 1'b1;
    if_addr = 32'h0000_0010;
    tick();
    chk("lf_en", mem_en, 1);
    chk("lf_addr", mem_addr, 8'h04);
    chk("lf_we", mem_we, 0);
    chk("lf_stall", stall_if, 1);
    tick();
    chk("lf_ready", if_ready, 1);
    chk("lf_rdata", if_rdata, 32'h2008_0005);
    chk("lf_stall_rsp", stall_if, 0);
    if_req = 1'b0;
    tick();

    // Store with three wait cycles
    fix_wait = 3;
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 32'h0000_0008;
    d_wdata = 32'hDEAD_BEEF;
    en_cnt = 0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      tick();
      if (mem_en) en_cnt++;
      if (d_ready) done = 1'b1;
    end
    chk("st_done", done, 1);
    chk("st_en_cycles", en_cnt, 4);
    d_req = 1'b0;
    tick();

    // Ack while idle is ignored
    mem_ack = 1'b1;
    mem_rdata = 32'h1234_5678;
    tick();
    chk("oog_ird", if_rdata, 32'h2008_0005);
    chk("oog_drd", d_rdata, 0);
    chk("oog_rdy", {if_ready, d_ready}, 0);

    // Simultaneous requests: data first
    fix_wait = -1;
    if_req = 1'b1;
    if_addr = $urandom;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = $urandom;
    first = -1;
    got_i = 1'b0;
    got_d = 1'b0;
    for (int c = 0; c < 60 && !(got_i && got_d); c++) begin
      tick();
      if (d_ready) begin
        if (first < 0) first = 1;
        got_d = 1'b1;
        d_req = 1'b0;
      end
      if (if_ready) begin
        if (first < 0) first = 0;
        got_i = 1'b1;
        if_req = 1'b0;
      end
    end
    chk("cf_both", got_i && got_d, 1);
    chk("cf_first_d", first, 1);

    // Starvation bound with data re-raised every time
    if_req = 1'b1;
    if_addr = $urandom;
    d_req = 1'b1;
    d_addr = $urandom;
    nd = 0;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      tick();
      if (d_ready) begin
        nd++;
        d_addr = $urandom;
      end
      if (if_ready) begin
        done = 1'b1;
        if_req = 1'b0;
        d_req = 1'b0;
      end
    end
    chk("sv_done", done, 1);
    chk("sv_d_grants", nd, MAXB);
    tick();
    tick();

    // Reset during a data access
    fix_wait = 1000;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = $urandom;
    tick();
    chk("rm_en", mem_en, 1);
    tick();
    rst = 1'b1;
    d_req = 1'b0;
    tick();
    chk("rm_en_off", mem_en, 0);
    chk("rm_no_rdy", d_ready, 0);
    rst = 1'b0;
    fix_wait = -1;
    mem_ack = 1'b1;
    tick();
    chk("rm_late_ack", d_ready, 0);
    tick();
    chk("rm_late_ack2", d_ready, 0);

    // Random traffic
    spur = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom_range(0, 299) == 0);
      if (rst) begin
        if_req = 1'b0;
        d_req = 1'b0;
      end else begin
        if (if_ready) if_req = 1'b0;
        if (d_ready) d_req = 1'b0;
        if (!if_req && $urandom_range(0, 1) == 1) begin
          if_req = 1'b1;
          if_addr = $urandom;
        end
        if (!d_req && $urandom_range(0, 1) == 1) begin
          d_req = 1'b1;
          d_we = 1'($urandom_range(0, 1));
          d_addr = $urandom;
          d_wdata = $urandom;
        end
      end
    end
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
